// File: rtl/pet_timing_pkg.sv
// Phase map shared by the PET bus timing generator: a 16-phase CPU cycle split
// into an SPI slot (phases 0-7) and a CPU slot (phases 8-15).
package pet_timing_pkg;

    localparam int PHASE_W = 4;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t SPI_SAMPLE_PH  = 4'd0;
    localparam phase_t SPI_GNT_FIRST  = 4'd1;
    localparam phase_t SPI_GNT_LAST   = 4'd7;
    localparam phase_t SPI_OE_FIRST   = 4'd2;
    localparam phase_t SPI_OE_LAST    = 4'd7;
    localparam phase_t SPI_WE_FIRST   = 4'd2;
    localparam phase_t SPI_WE_LAST    = 4'd6;
    localparam phase_t SPI_DONE_PH    = 4'd7;

    localparam phase_t CPU_SLOT_START = 4'd8;
    localparam phase_t CPU_OE_FIRST   = 4'd9;
    localparam phase_t CPU_OE_LAST    = 4'd15;
    localparam phase_t CPU_WE_FIRST   = 4'd10;
    localparam phase_t CPU_WE_LAST    = 4'd14;

    typedef struct packed {
        logic clk_cpu;
        logic cpu_en;
        logic cpu_ready;
        logic spi_grant;
        logic spi_done;
        logic ram_oe_n;
        logic ram_we_n;
    } bus_out_t;

    localparam bus_out_t BUS_OUT_RST = '{
        clk_cpu:   1'b0,
        cpu_en:    1'b0,
        cpu_ready: 1'b0,
        spi_grant: 1'b0,
        spi_done:  1'b0,
        ram_oe_n:  1'b1,
        ram_we_n:  1'b1
    };

    function automatic logic in_window(input phase_t ph, input phase_t first, input phase_t last);
        return (ph >= first) && (ph <= last);
    endfunction

endpackage

// File: rtl/pet_bus_timing.sv
// Generates the 1 MHz CPU clock, RAM strobes and SPI slot arbitration from a 16-phase counter.
// Latency: every output is registered; an SPI request seen at phase 0 is granted from phase 1.
// Backpressure: none; a request that misses phase 0 waits for the next one, one grant per assertion.
module pet_bus_timing
    import pet_timing_pkg::*;
#(
    parameter int CYCLE_LEN = 16
) (
    input  logic clk_16_i,
    input  logic reset_ni,
    input  logic bus_rw_ni,
    input  logic spi_req_i,
    input  logic spi_rw_ni,
    input  logic cpu_halt_i,
    output logic clk_cpu_o,
    output logic cpu_en_o,
    output logic cpu_ready_o,
    output logic spi_grant_o,
    output logic spi_done_o,
    output logic ram_oe_no,
    output logic ram_we_no
);

    localparam phase_t PHASE_LAST = phase_t'(CYCLE_LEN - 1);

    phase_t   phase_q;
    phase_t   phase_nxt;
    logic     cpu_rd_q;
    logic     spi_act_q;
    logic     spi_rd_q;
    logic     req_armed_q;
    logic     spi_start;
    logic     spi_act_eff;
    logic     spi_rd_eff;
    logic     cpu_rd_eff;
    bus_out_t out_q;
    bus_out_t out_nxt;

    // Outputs are computed for the phase being entered, so each register
    // already shows the value belonging to the current phase_q.
    always_comb begin
        phase_nxt   = (phase_q == PHASE_LAST) ? '0 : phase_t'(phase_q + 4'd1);
        spi_start   = (phase_q == SPI_SAMPLE_PH) && spi_req_i && req_armed_q;
        spi_act_eff = (phase_q == SPI_SAMPLE_PH) ? spi_start : spi_act_q;
        spi_rd_eff  = (phase_q == SPI_SAMPLE_PH) ? spi_rw_ni : spi_rd_q;
        cpu_rd_eff  = (phase_q == CPU_SLOT_START) ? bus_rw_ni : cpu_rd_q;

        out_nxt           = out_q;
        out_nxt.clk_cpu   = (phase_nxt >= CPU_SLOT_START);
        out_nxt.cpu_en    = (phase_nxt >= CPU_SLOT_START);
        if (phase_nxt == '0) begin
            out_nxt.cpu_ready = !cpu_halt_i;
        end
        out_nxt.spi_grant = spi_act_eff && in_window(phase_nxt, SPI_GNT_FIRST, SPI_GNT_LAST);
        out_nxt.spi_done  = spi_act_eff && (phase_nxt == SPI_DONE_PH);
        // The CPU and SPI windows are disjoint and exclude phases 0, 1 and 8,
        // so the two strobes can never overlap and the bus gets its turnaround.
        out_nxt.ram_oe_n  = !((cpu_rd_eff && in_window(phase_nxt, CPU_OE_FIRST, CPU_OE_LAST)) ||
                              (spi_act_eff && spi_rd_eff &&
                               in_window(phase_nxt, SPI_OE_FIRST, SPI_OE_LAST)));
        out_nxt.ram_we_n  = !((!cpu_rd_eff && in_window(phase_nxt, CPU_WE_FIRST, CPU_WE_LAST)) ||
                              (spi_act_eff && !spi_rd_eff &&
                               in_window(phase_nxt, SPI_WE_FIRST, SPI_WE_LAST)));
    end

    always_ff @(posedge clk_16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase_q     <= '0;
            cpu_rd_q    <= 1'b1;
            spi_act_q   <= 1'b0;
            spi_rd_q    <= 1'b1;
            req_armed_q <= 1'b0;
            out_q       <= BUS_OUT_RST;
        end else begin
            phase_q   <= phase_nxt;
            cpu_rd_q  <= cpu_rd_eff;
            spi_act_q <= spi_act_eff;
            spi_rd_q  <= spi_rd_eff;
            // Re-armed only by seeing the request low, so a held request is granted once.
            if (spi_start) begin
                req_armed_q <= 1'b0;
            end else if (!spi_req_i) begin
                req_armed_q <= 1'b1;
            end
            out_q <= out_nxt;
        end
    end

    assign clk_cpu_o   = out_q.clk_cpu;
    assign cpu_en_o    = out_q.cpu_en;
    assign cpu_ready_o = out_q.cpu_ready;
    assign spi_grant_o = out_q.spi_grant;
    assign spi_done_o  = out_q.spi_done;
    assign ram_oe_no   = out_q.ram_oe_n;
    assign ram_we_no   = out_q.ram_we_n;

endmodule

// File: tb/tb_pet_bus_timing.sv
// Bench for pet_bus_timing: directed tables plus a cycle-indexed reference model.
module tb_pet_bus_timing;

    localparam int HMAX = 8192;

    logic clk_16_i   = 1'b0;
    logic reset_ni   = 1'b0;
    logic bus_rw_ni  = 1'b1;
    logic spi_req_i  = 1'b0;
    logic spi_rw_ni  = 1'b1;
    logic cpu_halt_i = 1'b0;
    logic clk_cpu_o, cpu_en_o, cpu_ready_o, spi_grant_o, spi_done_o, ram_oe_no, ram_we_no;

    pet_bus_timing #(.CYCLE_LEN(16)) dut (
        .clk_16_i   (clk_16_i),
        .reset_ni   (reset_ni),
        .bus_rw_ni  (bus_rw_ni),
        .spi_req_i  (spi_req_i),
        .spi_rw_ni  (spi_rw_ni),
        .cpu_halt_i (cpu_halt_i),
        .clk_cpu_o  (clk_cpu_o),
        .cpu_en_o   (cpu_en_o),
        .cpu_ready_o(cpu_ready_o),
        .spi_grant_o(spi_grant_o),
        .spi_done_o (spi_done_o),
        .ram_oe_no  (ram_oe_no),
        .ram_we_no  (ram_we_no)
    );

    always #5 clk_16_i = ~clk_16_i;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    bit model_en = 1'b0;

    // Per-cycle input history of the current reset segment; cycle 0 is the release cycle.
    bit req_h [HMAX];
    bit srw_h [HMAX];
    bit brw_h [HMAX];
    bit halt_h[HMAX];
    int last_low;
    int last_grant;
    bit slot_g;
    bit slot_rd;

    typedef struct {
        bit          rw;
        bit          toggle11;
        logic [15:0] exp_oe;
        logic [15:0] exp_we;
    } cpu_vec_t;

    typedef struct {
        int          raise_ph;
        bit          rw;
        int          exp_delay;
        logic [15:0] exp_gnt;
        logic [15:0] exp_oe;
        logic [15:0] exp_we;
        logic [15:0] exp_done;
    } spi_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    function automatic logic [6:0] act_vec();
        return {clk_cpu_o, cpu_en_o, cpu_ready_o, spi_grant_o, spi_done_o, ram_oe_no, ram_we_no};
    endfunction

    task automatic model_init();
        last_low   = -1;
        last_grant = -1;
        slot_g     = 1'b0;
        slot_rd    = 1'b1;
        model_en   = 1'b1;
    endtask

    // Advance one clock: record inputs at the edge, compare at the falling edge.
    task automatic tick();
        int   p;
        int   s;
        logic clk_e, rdy_e, gnt_e, done_e, oe_low, we_low, cr;
        @(posedge clk_16_i);
        if (model_en) begin
            req_h[t]  = spi_req_i;
            srw_h[t]  = spi_rw_ni;
            brw_h[t]  = bus_rw_ni;
            halt_h[t] = cpu_halt_i;
            if (!spi_req_i) last_low = t;
        end
        @(negedge clk_16_i);
        t++;
        if (t >= HMAX - 16) model_en = 1'b0;
        if (model_en) begin
            p = t % 16;
            s = t - p;
            if (p == 1) begin
                // One grant per assertion: the request must have been low since the last grant.
                slot_g  = req_h[s] && (last_low > last_grant);
                slot_rd = srw_h[s];
                if (slot_g) last_grant = s;
            end
            clk_e  = (p >= 8);
            rdy_e  = (t >= 16) ? !halt_h[s - 1] : 1'b0;
            cr     = brw_h[s + 8];
            gnt_e  = slot_g && (p >= 1) && (p <= 7);
            done_e = slot_g && (p == 7);
            oe_low = ((p >= 9) && cr) || (slot_g && slot_rd && (p >= 2) && (p <= 7));
            we_low = ((p >= 10) && (p <= 14) && !cr) || (slot_g && !slot_rd && (p >= 2) && (p <= 6));
            chk("model", 32'(act_vec()), 32'({clk_e, clk_e, rdy_e, gnt_e, done_e, !oe_low, !we_low}));
        end
    endtask

    task automatic tick_to(input int ph);
        for (int k = 0; k < 17 && (t % 16) != ph; k++) tick();
    endtask

    task automatic apply_reset();
        model_en = 1'b0;
        @(negedge clk_16_i);
        reset_ni  = 1'b0;
        spi_req_i = 1'b0;
        #1;
        chk("reset_outputs", 32'(act_vec()), 32'(7'b0000011));
        repeat (3) @(negedge clk_16_i);
        chk("reset_outputs_clocked", 32'(act_vec()), 32'(7'b0000011));
        reset_ni = 1'b1;
        t = 0;
        model_init();
    endtask

    cpu_vec_t cpu_tab[4];
    spi_vec_t spi_tab[4];

    initial begin
        logic [15:0] oe_m, we_m, g_m, d_m;
        int          overlap, first_g, g_tot, d_tot, t_raise, done_seen;

        cpu_tab[0] = '{rw: 1'b1, toggle11: 1'b0, exp_oe: 16'hFE00, exp_we: 16'h0000};
        cpu_tab[1] = '{rw: 1'b0, toggle11: 1'b0, exp_oe: 16'h0000, exp_we: 16'h7C00};
        cpu_tab[2] = '{rw: 1'b0, toggle11: 1'b1, exp_oe: 16'h0000, exp_we: 16'h7C00};
        cpu_tab[3] = '{rw: 1'b1, toggle11: 1'b1, exp_oe: 16'hFE00, exp_we: 16'h0000};

        spi_tab[0] = '{raise_ph: 3,  rw: 1'b0, exp_delay: 14, exp_gnt: 16'h00FE,
                       exp_oe: 16'h0000, exp_we: 16'h007C, exp_done: 16'h0080};
        spi_tab[1] = '{raise_ph: 15, rw: 1'b1, exp_delay: 2,  exp_gnt: 16'h00FE,
                       exp_oe: 16'h00FC, exp_we: 16'h0000, exp_done: 16'h0080};
        spi_tab[2] = '{raise_ph: 0,  rw: 1'b1, exp_delay: 1,  exp_gnt: 16'h00FE,
                       exp_oe: 16'h00FC, exp_we: 16'h0000, exp_done: 16'h0080};
        spi_tab[3] = '{raise_ph: 1,  rw: 1'b0, exp_delay: 16, exp_gnt: 16'h00FE,
                       exp_oe: 16'h0000, exp_we: 16'h007C, exp_done: 16'h0080};

        apply_reset();

        // Free run: CPU clock low for 8, high for 8, bus enable follows it.
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("clk_cpu_phase", 32'(clk_cpu_o), 32'((t % 16) >= 8));
            chk("cpu_en_phase", 32'(cpu_en_o), 32'((t % 16) >= 8));
        end

        // CPU slot strobes, direction sampled at phase 8 only.
        foreach (cpu_tab[i]) begin
            tick_to(7);
            bus_rw_ni = ~cpu_tab[i].rw;
            oe_m = '0; we_m = '0; overlap = 0;
            for (int k = 0; k < 9; k++) begin
                if (k > 0) tick();
                if (!ram_oe_no) oe_m[t % 16] = 1'b1;
                if (!ram_we_no) we_m[t % 16] = 1'b1;
                if (!ram_oe_no && !ram_we_no) overlap++;
                if ((t % 16) == 8) bus_rw_ni = cpu_tab[i].rw;
                if ((t % 16) == 11 && cpu_tab[i].toggle11) bus_rw_ni = ~cpu_tab[i].rw;
            end
            chk($sformatf("cpu%0d_oe_mask", i), 32'(oe_m), 32'(cpu_tab[i].exp_oe));
            chk($sformatf("cpu%0d_we_mask", i), 32'(we_m), 32'(cpu_tab[i].exp_we));
            chk($sformatf("cpu%0d_overlap", i), 32'(overlap), 32'd0);
        end
        bus_rw_ni = 1'b0;

        // SPI slots: raise phase decides which slot, held request is granted once.
        foreach (spi_tab[i]) begin
            spi_req_i = 1'b0;
            tick();
            tick_to(spi_tab[i].raise_ph);
            spi_req_i = 1'b1;
            spi_rw_ni = spi_tab[i].rw;
            t_raise   = t;
            first_g = -1; g_tot = 0; d_tot = 0;
            g_m = '0; oe_m = '0; we_m = '0; d_m = '0;
            for (int k = 0; k < 48; k++) begin
                tick();
                if (spi_grant_o && first_g < 0) first_g = t;
                g_tot += int'(spi_grant_o);
                d_tot += int'(spi_done_o);
                if (first_g >= 0 && (t - (first_g - first_g % 16)) < 8) begin
                    if (spi_grant_o) g_m[t % 16] = 1'b1;
                    if (!ram_oe_no)  oe_m[t % 16] = 1'b1;
                    if (!ram_we_no)  we_m[t % 16] = 1'b1;
                    if (spi_done_o)  d_m[t % 16] = 1'b1;
                end
            end
            chk($sformatf("spi%0d_delay", i), 32'(first_g - t_raise), 32'(spi_tab[i].exp_delay));
            chk($sformatf("spi%0d_grant_mask", i), 32'(g_m), 32'(spi_tab[i].exp_gnt));
            chk($sformatf("spi%0d_oe_mask", i), 32'(oe_m), 32'(spi_tab[i].exp_oe));
            chk($sformatf("spi%0d_we_mask", i), 32'(we_m), 32'(spi_tab[i].exp_we));
            chk($sformatf("spi%0d_done_mask", i), 32'(d_m), 32'(spi_tab[i].exp_done));
            chk($sformatf("spi%0d_grant_total", i), 32'(g_tot), 32'd7);
            chk($sformatf("spi%0d_done_total", i), 32'(d_tot), 32'd1);
        end
        spi_req_i = 1'b0;

        // Halt: RDY changes only at phase 0, SPI keeps being served.
        tick_to(5);
        cpu_halt_i = 1'b1;
        tick_to(15);
        chk("halt_ready_before_ph0", 32'(cpu_ready_o), 32'd1);
        tick();
        chk("halt_ready_at_ph0", 32'(cpu_ready_o), 32'd0);
        tick_to(2);
        spi_req_i = 1'b1;
        spi_rw_ni = 1'b0;
        g_tot = 0; d_tot = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            g_tot += int'(spi_grant_o);
            d_tot += int'(spi_done_o);
        end
        chk("halt_spi_grant_total", 32'(g_tot), 32'd7);
        chk("halt_spi_done_total", 32'(d_tot), 32'd1);
        spi_req_i  = 1'b0;
        cpu_halt_i = 1'b0;
        tick();
        tick_to(0);
        chk("unhalt_ready", 32'(cpu_ready_o), 32'd1);

        // Random traffic against the model.
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(7) == 0) spi_req_i = ~spi_req_i;
            spi_rw_ni = 1'($urandom);
            bus_rw_ni = 1'($urandom);
            if ($urandom_range(31) == 0) cpu_halt_i = ~cpu_halt_i;
            tick();
        end
        spi_req_i  = 1'b0;
        cpu_halt_i = 1'b0;

        // Reset during a granted SPI read.
        tick();
        tick_to(15);
        spi_req_i = 1'b1;
        spi_rw_ni = 1'b1;
        tick_to(4);
        chk("pre_reset_grant", 32'(spi_grant_o), 32'd1);
        chk("pre_reset_oe", 32'(ram_oe_no), 32'd0);
        model_en = 1'b0;
        #2;
        reset_ni  = 1'b0;
        spi_req_i = 1'b0;
        #1;
        chk("reset_mid_spi_outputs", 32'(act_vec()), 32'(7'b0000011));
        done_seen = 0;
        repeat (6) begin
            @(negedge clk_16_i);
            done_seen += int'(spi_done_o);
        end
        chk("reset_mid_spi_no_done", 32'(done_seen), 32'd0);
        reset_ni = 1'b1;
        t = 0;
        model_init();
        tick_to(2);
        spi_req_i = 1'b1;
        spi_rw_ni = 1'b1;
        g_tot = 0;
        tick_to(7);
        chk("restart_clk_ph7", 32'(clk_cpu_o), 32'd0);
        tick();
        chk("restart_clk_ph8", 32'(clk_cpu_o), 32'd1);
        for (int k = 0; k < 9; k++) begin
            tick();
            if (t < 17) g_tot += int'(spi_grant_o);
        end
        chk("rerequest_no_early_grant", 32'(g_tot), 32'd0);
        chk("rerequest_grant_t17", 32'(spi_grant_o), 32'd1);
        spi_req_i = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
